muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; datapath fixed at 32 bits.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst_b  in  1  reset, asynchronous, active-high (asserted = 1).
REQ-004 start  in  1  request strobe; sampled on the rising edge of clk.
REQ-005 func  in  6  operation select, R-type funct encoding:
- MULT 011000, MULTU 011001, DIV 011010, DIVU 011011
- MTHI 010001, MTLO 010011
REQ-006 rs  in  32  operand A: dividend / multiplicand / MTHI-MTLO source.
REQ-007 rt  in  32  operand B: divisor / multiplier.
REQ-008 flush  in  1  synchronous abort of the operation in flight.
REQ-009 busy  out  1  operation in flight; new requests are not accepted.
REQ-010 done  out  1  one-cycle pulse; HI/LO or dz updated at the same edge.
REQ-011 dz  out  1  divide-by-zero flag, valid while done=1.
REQ-012 hi  out  32  HI register, driven directly from a flop.
REQ-013 lo  out  32  LO register, driven directly from a flop.

Function
REQ-014 States: IDLE, MUL, DIV, FIX, DZ.
REQ-015 Accept: request accepted at edge E0 when state=IDLE and start=1 and func is a recognised code.
REQ-016 Start while busy, and start with an unrecognised func, are both ignored with no state change.
REQ-017 MTHI/MTLO: hi (or lo) <= rs at E0; busy and done stay 0; state remains IDLE.
REQ-018 MULT/MULTU: at E0, latch operand magnitudes and result sign, then enter MUL.
- Signed ops use the two's-complement magnitude; sign = rs[31]^rt[31].
- Unsigned ops use sign = 0.
REQ-019 MUL: one shift-add step per cycle at edges E1..E32, using a 64-bit accumulator, then go to FIX.
REQ-020 DIV/DIVU with rt!=0: at E0, latch operand magnitudes; quotient sign = rs[31]^rt[31]; remainder sign = rs[31]. Enter DIV.
REQ-021 DIV: one restoring shift-subtract step per cycle at E1..E32, then go to FIX.
REQ-022 FIX at E33 writes the sign-corrected result:
- MUL: {hi,lo} <= 64-bit product.
- DIV: lo <= quotient, hi <= remainder.
- done=1 for the cycle after E33; state returns to IDLE.
REQ-023 busy=1 from after E0 until E33; busy=0 in the cycle done=1; a new start is accepted in that cycle.
REQ-024 Latency: 33 cycles from acceptance to done, independent of operand values.
REQ-025 Signed DIV 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0x00000000 with no flag.
REQ-026 DIV/DIVU with rt=0: enter DZ at E0 (busy=1); at E1, done=1 and dz=1; hi/lo unchanged; state returns to IDLE.
REQ-027 dz=0 on every done pulse other than the divide-by-zero case.
REQ-028 flush=1 in MUL/DIV/FIX/DZ: return to IDLE at the next edge with no done and hi/lo unchanged.
REQ-029 flush=1 together with start in IDLE: flush wins and the request is dropped.
REQ-030 Partial results never appear on hi/lo.

Reset
REQ-031 rst_b=1 immediately forces the following, independent of clk and mid-operation included:
- state=IDLE
- busy=0, done=0, dz=0
- hi=0, lo=0
- internal accumulator, counter and sign latches = 0
REQ-032 The first request is accepted on the first rising edge after rst_b deasserts.

Verification
REQ-033 MULT rs=0xFFFFFFFF, rt=0x00000002 -> done 33 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFFE, dz=0.
REQ-034 MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-035 DIV rs=0xFFFFFFF9 (-7), rt=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU 100/7 -> lo=0x0000000E, hi=0x00000002.
REQ-036 MTHI rs=0x12345678, then DIVU rt=0 -> hi=0x12345678 at once; DIVU gives done and dz=1 one cycle after accept, with hi/lo unchanged.
REQ-037 MULT accepted; start pulsed at cycle 3; flush at cycle 10 -> second start ignored; busy=0 after the flush edge; no done pulse; hi/lo hold their prior values.
REQ-038 rst_b pulsed at cycle 5 of a DIV, between clock edges -> busy, hi, lo drop to 0 before the next edge; a MULTU 3x5 issued after release -> lo=0x0000000F, hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then a sign-fix cycle.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start,
  input  logic [5:0]  func,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic        dz,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DZ   = 3'd4
  } state_t;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  state_t      state_r, state_n;
  logic [63:0] acc_r, acc_n;
  logic [31:0] a_r, a_n, b_r, b_n;
  logic [4:0]  cnt_r, cnt_n;
  logic        sq_r, sq_n, sr_r, sr_n, is_div_r, is_div_n;
  logic [31:0] hi_r, hi_n, lo_r, lo_n;
  logic        busy_r, done_r, done_n, dz_r, dz_n;

  logic        sgn_s;
  logic [31:0] mag_a_s, mag_b_s;
  logic [32:0] mul_sum_s, div_sh_s, div_diff_s;
  logic [63:0] prod_s;

  assign sgn_s      = ~func[0];
  assign mag_a_s    = (sgn_s && rs[31]) ? neg32(rs) : rs;
  assign mag_b_s    = (sgn_s && rt[31]) ? neg32(rt) : rt;
  // Multiplier sits in acc low half and shifts out as the partial product shifts in.
  assign mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, a_r} : 33'd0);
  assign div_sh_s   = {acc_r[63:32], acc_r[31]};
  assign div_diff_s = div_sh_s - {1'b0, b_r};
  assign prod_s     = sq_r ? neg64(acc_r) : acc_r;

  // Next-state and datapath update.
  always_comb begin
    state_n  = state_r;
    acc_n    = acc_r;
    a_n      = a_r;
    b_n      = b_r;
    cnt_n    = cnt_r;
    sq_n     = sq_r;
    sr_n     = sr_r;
    is_div_n = is_div_r;
    hi_n     = hi_r;
    lo_n     = lo_r;
    done_n   = 1'b0;
    dz_n     = 1'b0;
    case (state_r)
      IDLE: begin
        if (flush) begin
          state_n = IDLE;
        end else if (start) begin
          case (func)
            F_MTHI: hi_n = rs;
            F_MTLO: lo_n = rs;
            F_MULT, F_MULTU: begin
              a_n      = mag_a_s;
              acc_n    = {32'd0, mag_b_s};
              sq_n     = sgn_s & (rs[31] ^ rt[31]);
              sr_n     = 1'b0;
              is_div_n = 1'b0;
              cnt_n    = 5'd0;
              state_n  = MUL;
            end
            F_DIV, F_DIVU: begin
              if (rt == 32'd0) begin
                state_n = DZ;
              end else begin
                acc_n    = {32'd0, mag_a_s};
                b_n      = mag_b_s;
                sq_n     = sgn_s & (rs[31] ^ rt[31]);
                sr_n     = sgn_s & rs[31];
                is_div_n = 1'b1;
                cnt_n    = 5'd0;
                state_n  = DIV;
              end
            end
            default: state_n = IDLE;
          endcase
        end else begin
          state_n = IDLE;
        end
      end
      MUL, DIV: begin
        if (flush) begin
          state_n = IDLE;
        end else begin
          if (state_r == MUL) begin
            acc_n = {mul_sum_s, acc_r[31:1]};
          end else if (div_diff_s[32]) begin
            acc_n = {div_sh_s[31:0], acc_r[30:0], 1'b0};
          end else begin
            acc_n = {div_diff_s[31:0], acc_r[30:0], 1'b1};
          end
          cnt_n = cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            state_n = FIX;
          end else begin
            state_n = state_r;
          end
        end
      end
      FIX: begin
        if (flush) begin
          state_n = IDLE;
        end else begin
          if (is_div_r) begin
            lo_n = sq_r ? neg32(acc_r[31:0]) : acc_r[31:0];
            hi_n = sr_r ? neg32(acc_r[63:32]) : acc_r[63:32];
          end else begin
            hi_n = prod_s[63:32];
            lo_n = prod_s[31:0];
          end
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      DZ: begin
        if (flush) begin
          state_n = IDLE;
        end else begin
          done_n  = 1'b1;
          dz_n    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_r  <= IDLE;
      acc_r    <= 64'd0;
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      cnt_r    <= 5'd0;
      sq_r     <= 1'b0;
      sr_r     <= 1'b0;
      is_div_r <= 1'b0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dz_r     <= 1'b0;
    end else begin
      state_r  <= state_n;
      acc_r    <= acc_n;
      a_r      <= a_n;
      b_r      <= b_n;
      cnt_r    <= cnt_n;
      sq_r     <= sq_n;
      sr_r     <= sr_n;
      is_div_r <= is_div_n;
      hi_r     <= hi_n;
      lo_r     <= lo_n;
      busy_r   <= (state_n != IDLE);
      done_r   <= done_n;
      dz_r     <= dz_n;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign dz   = dz_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  func = 6'd0;
  logic [31:0] rs = 32'd0;
  logic [31:0] rt = 32'd0;
  logic        flush = 1'b0;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  muldiv_unit dut (
    .clk(clk), .rst_b(rst_b), .start(start), .func(func), .rs(rs), .rt(rt),
    .flush(flush), .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; func = f; rs = a; rt = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    #2 rst_b = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0 || dz !== 1'b0) begin failures++; $display("FAIL reset_done_dz got=%b%b exp=00", done, dz); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("FAIL reset_hilo got=%h_%h exp=0", hi, lo); end
    rst_b = 1'b0;
  endtask

  task automatic test_mult;
    int lat;
    issue(F_MULT, 32'hFFFFFFFF, 32'h00000002);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mult_busy got=%b exp=1", busy); end
    wait_done(lat);
    checks++; if (lat !== 33) begin failures++; $display("FAIL mult_latency got=%0d exp=33", lat); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mult_busy_at_done got=%b exp=0", busy); end
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE || dz !== 1'b0) begin
      failures++; $display("FAIL mult_result got=%h_%h dz=%b exp=ffffffff_fffffffe dz=0", hi, lo, dz); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
    issue(F_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB);
    wait_done(lat);
    checks++; if (hi !== 32'h00000000 || lo !== 32'h0000000F) begin
      failures++; $display("FAIL mult_negneg got=%h_%h exp=00000000_0000000f", hi, lo); end
    issue(F_MULT, 32'h80000000, 32'h80000000);
    wait_done(lat);
    checks++; if (hi !== 32'h40000000 || lo !== 32'h00000000) begin
      failures++; $display("FAIL mult_minmin got=%h_%h exp=40000000_00000000", hi, lo); end
    issue(F_MULTU, 32'hFFFFFFFF, 32'h00000002);
    wait_done(lat);
    checks++; if (lat !== 33 || hi !== 32'h00000001 || lo !== 32'hFFFFFFFE) begin
      failures++; $display("FAIL multu_result got=%h_%h lat=%0d exp=00000001_fffffffe lat=33", hi, lo, lat); end
  endtask

  task automatic test_div;
    int lat;
    issue(F_DIV, 32'hFFFFFFF9, 32'h00000002);
    wait_done(lat);
    checks++; if (lat !== 33 || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF || dz !== 1'b0) begin
      failures++; $display("FAIL div_neg7_2 got=lo %h hi %h lat %0d dz %b exp=lo fffffffd hi ffffffff lat 33 dz 0", lo, hi, lat, dz); end
    issue(F_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat);
    checks++; if (lo !== 32'h80000000 || hi !== 32'h00000000 || dz !== 1'b0) begin
      failures++; $display("FAIL div_overflow got=lo %h hi %h dz %b exp=lo 80000000 hi 0 dz 0", lo, hi, dz); end
  endtask

  task automatic test_back_to_back;
    int lat;
    issue(F_MULTU, 32'd6, 32'd7);
    wait_done(lat);
    issue(F_DIVU, 32'd100, 32'd7);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    wait_done(lat);
    checks++; if (lat !== 33 || lo !== 32'h0000000E || hi !== 32'h00000002) begin
      failures++; $display("FAIL b2b_divu got=lo %h hi %h lat %0d exp=lo e hi 2 lat 33", lo, hi, lat); end
  endtask

  task automatic test_mthi_dz;
    int lat;
    issue(F_MTHI, 32'h12345678, 32'd0);
    checks++; if (hi !== 32'h12345678 || lo !== 32'h0000000E || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL mthi got=hi %h lo %h busy %b done %b exp=hi 12345678 lo e busy 0 done 0", hi, lo, busy, done); end
    issue(F_DIVU, 32'd55, 32'd0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL dz_busy got=%b exp=1", busy); end
    wait_done(lat);
    checks++; if (lat !== 1 || dz !== 1'b1 || hi !== 32'h12345678 || lo !== 32'h0000000E) begin
      failures++; $display("FAIL divu_zero got=lat %0d dz %b hi %h lo %h exp=lat 1 dz 1 hi 12345678 lo e", lat, dz, hi, lo); end
    issue(F_MTLO, 32'hCAFEF00D, 32'd0);
    checks++; if (lo !== 32'hCAFEF00D || hi !== 32'h12345678) begin
      failures++; $display("FAIL mtlo got=hi %h lo %h exp=hi 12345678 lo cafef00d", hi, lo); end
  endtask

  task automatic test_ignored;
    issue(6'b000000, 32'h11111111, 32'h22222222);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bad_func got busy=%b exp=0", busy); end
    flush = 1'b1;
    issue(F_MTHI, 32'hDEADBEEF, 32'd0);
    issue(F_MULT, 32'd3, 32'd3);
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || hi !== 32'h12345678) begin
      failures++; $display("FAIL flush_idle got=busy %b hi %h exp=busy 0 hi 12345678", busy, hi); end
  endtask

  task automatic test_flush;
    int seen;
    issue(F_MULT, 32'd7, 32'd9);
    repeat (2) begin @(posedge clk); #1; end
    issue(F_DIVU, 32'd100, 32'd7);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_busy_mid got=%b exp=1", busy); end
    repeat (6) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL flush_abort got=busy %b done %b exp=0 0", busy, done); end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
    checks++; if (hi !== 32'h12345678 || lo !== 32'hCAFEF00D) begin
      failures++; $display("FAIL flush_hilo got=%h_%h exp=12345678_cafef00d", hi, lo); end
  endtask

  task automatic test_reset_mid;
    int lat;
    issue(F_DIV, 32'd1000, 32'd3);
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_b = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++; $display("FAIL async_reset got=busy %b hi %h lo %h exp=0 0 0", busy, hi, lo); end
    #2 rst_b = 1'b0;
    @(posedge clk); #1;
    issue(F_MULTU, 32'd3, 32'd5);
    wait_done(lat);
    checks++; if (lat !== 33 || lo !== 32'h0000000F || hi !== 32'd0) begin
      failures++; $display("FAIL post_reset_multu got=lo %h hi %h lat %0d exp=lo f hi 0 lat 33", lo, hi, lat); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_back_to_back();
    test_mthi_dz();
    test_ignored();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
